// File: rtl/tetris_pkg.sv
// Shared board geometry, clear-engine state encoding and small helpers
// used by the row-clear logic.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam logic [BOARD_COLS-1:0] FULL_ROW = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FILL,
    ST_REPORT,
    ST_HOLD,
    ST_UPDATE
  } clear_state_t;

  // The scoring interface only carries 3 bits of cleared-row count.
  function automatic logic [2:0] sat7(input logic [4:0] n);
    return (n > 5'd7) ? 3'd7 : n[2:0];
  endfunction

endpackage

// File: rtl/line_level_tracker.sv
// Running line total (saturating at 999) and the level derived from it;
// both load only on the update strobe.
module line_level_tracker #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 29
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       update_in,
  input  logic [4:0] count_in,
  output logic [9:0] lines_out,
  output logic [4:0] level_out
);
  import tetris_pkg::*;

  logic [9:0]  lines_q, lines_d;
  logic [4:0]  level_q, level_d;
  logic [10:0] sum;
  logic [9:0]  lines_new;
  logic [9:0]  level_calc;

  always_comb begin
    sum        = {1'b0, lines_q} + {6'd0, count_in};
    lines_new  = (sum > 11'd999) ? 10'd999 : sum[9:0];
    level_calc = 10'd1 + lines_new / 10'(LINES_PER_LEVEL);
    lines_d    = lines_q;
    level_d    = level_q;
    if (update_in) begin
      lines_d = lines_new;
      level_d = (level_calc > 10'(MAX_LEVEL)) ? 5'(MAX_LEVEL) : level_calc[4:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lines_q <= 10'd0;
      level_q <= 5'd1;
    end else begin
      lines_q <= lines_d;
      level_q <= level_d;
    end
  end

  assign lines_out = lines_q;
  assign level_out = level_q;

endmodule

// File: rtl/line_clear.sv
// Row-clear engine: bottom-up scan that compacts non-full rows in place,
// zero-fills the freed top rows, then reports the count to scoring.
module line_clear #(
  parameter int BOARD_ROWS      = tetris_pkg::BOARD_ROWS,
  parameter int BOARD_COLS      = tetris_pkg::BOARD_COLS,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 29
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  lock_in,
  output logic [4:0]            rd_addr_out,
  input  logic [BOARD_COLS-1:0] rd_data_in,
  output logic                  wr_en_out,
  output logic [4:0]            wr_addr_out,
  output logic [BOARD_COLS-1:0] wr_data_out,
  output logic                  busy_out,
  output logic                  score_start_out,
  output logic [2:0]            rows_cleared_out,
  output logic [4:0]            level_out,
  output logic [9:0]            lines_out
);
  import tetris_pkg::*;

  localparam logic [4:0] LAST_ROW = 5'(BOARD_ROWS - 1);
  localparam logic [4:0] ROWS_W   = 5'(BOARD_ROWS);
  localparam logic [4:0] SCAN_END = 5'(BOARD_ROWS + 1);

  clear_state_t          state_q, state_d;
  logic [4:0]            scan_cnt_q, scan_cnt_d;
  logic [4:0]            count_q, count_d;
  logic [4:0]            wp_q, wp_d;
  logic [4:0]            fill_left_q, fill_left_d;
  logic [1:0]            hold_cnt_q, hold_cnt_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [BOARD_COLS-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  score_start_q, score_start_d;
  logic [2:0]            rows_cleared_q, rows_cleared_d;
  logic                  update_strobe;

  always_comb begin
    state_d        = state_q;
    scan_cnt_d     = scan_cnt_q;
    count_d        = count_q;
    wp_d           = wp_q;
    fill_left_d    = fill_left_q;
    hold_cnt_d     = hold_cnt_q;
    rd_addr_d      = rd_addr_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    busy_d         = busy_q;
    score_start_d  = 1'b0;
    rows_cleared_d = rows_cleared_q;
    case (state_q)
      ST_IDLE: begin
        if (lock_in) begin
          state_d    = ST_SCAN;
          busy_d     = 1'b1;
          rd_addr_d  = LAST_ROW;
          wp_d       = LAST_ROW;
          count_d    = 5'd0;
          scan_cnt_d = 5'd0;
        end
      end
      ST_SCAN: begin
        // scan_cnt k issues read k and consumes the row read at k-1
        scan_cnt_d = scan_cnt_q + 5'd1;
        if (scan_cnt_q < LAST_ROW) rd_addr_d = rd_addr_q - 5'd1;
        if (scan_cnt_q != 5'd0 && scan_cnt_q <= ROWS_W) begin
          if (&rd_data_in) begin
            count_d = count_q + 5'd1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = wp_q;
            wr_data_d = rd_data_in;
            wp_d      = wp_q - 5'd1;
          end
        end
        if (scan_cnt_q == SCAN_END) begin
          if (count_q != 5'd0) begin
            state_d     = ST_FILL;
            wr_en_d     = 1'b1;
            wr_addr_d   = wp_q;
            wr_data_d   = '0;
            wp_d        = wp_q - 5'd1;
            fill_left_d = count_q - 5'd1;
          end else begin
            state_d        = ST_REPORT;
            score_start_d  = 1'b1;
            rows_cleared_d = sat7(count_q);
          end
        end
      end
      ST_FILL: begin
        if (fill_left_q != 5'd0) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = wp_q;
          wr_data_d   = '0;
          wp_d        = wp_q - 5'd1;
          fill_left_d = fill_left_q - 5'd1;
        end else begin
          state_d        = ST_REPORT;
          score_start_d  = 1'b1;
          rows_cleared_d = sat7(count_q);
        end
      end
      ST_REPORT: begin
        state_d    = ST_HOLD;
        hold_cnt_d = 2'd0;
      end
      ST_HOLD: begin
        if (hold_cnt_q == 2'd2) state_d = ST_UPDATE;
        else hold_cnt_d = hold_cnt_q + 2'd1;
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      scan_cnt_q     <= 5'd0;
      count_q        <= 5'd0;
      wp_q           <= LAST_ROW;
      fill_left_q    <= 5'd0;
      hold_cnt_q     <= 2'd0;
      rd_addr_q      <= LAST_ROW;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= LAST_ROW;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      score_start_q  <= 1'b0;
      rows_cleared_q <= 3'd0;
    end else begin
      state_q        <= state_d;
      scan_cnt_q     <= scan_cnt_d;
      count_q        <= count_d;
      wp_q           <= wp_d;
      fill_left_q    <= fill_left_d;
      hold_cnt_q     <= hold_cnt_d;
      rd_addr_q      <= rd_addr_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      busy_q         <= busy_d;
      score_start_q  <= score_start_d;
      rows_cleared_q <= rows_cleared_d;
    end
  end

  assign update_strobe = (state_q == ST_UPDATE);

  line_level_tracker #(
    .LINES_PER_LEVEL(LINES_PER_LEVEL),
    .MAX_LEVEL      (MAX_LEVEL)
  ) u_tracker (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .update_in(update_strobe),
    .count_in (count_q),
    .lines_out(lines_out),
    .level_out(level_out)
  );

  assign rd_addr_out      = rd_addr_q;
  assign wr_en_out        = wr_en_q;
  assign wr_addr_out      = wr_addr_q;
  assign wr_data_out      = wr_data_q;
  assign busy_out         = busy_q;
  assign score_start_out  = score_start_q;
  assign rows_cleared_out = rows_cleared_q;

endmodule

// File: tb/tb_line_clear.sv
// Bench for line_clear: a row memory around the DUT, a list-filtering board
// model and an arithmetic line/level model, with directed and random passes.
module tb_line_clear;

  localparam logic [9:0] FULL = 10'h3ff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock = 1'b0;
  logic [4:0] rd_addr;
  logic [9:0] rd_data;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [9:0] wr_data;
  logic       busy;
  logic       score_start;
  logic [2:0] rows_cleared;
  logic [4:0] level;
  logic [9:0] lines;

  logic [9:0] mem [20];
  logic [9:0] init_board [20];
  logic       load_req = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         lines_m = 0;
  int         lvl_m = 1;
  int         pass_no = 0;

  line_clear dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .lock_in         (lock),
    .rd_addr_out     (rd_addr),
    .rd_data_in      (rd_data),
    .wr_en_out       (wr_en),
    .wr_addr_out     (wr_addr),
    .wr_data_out     (wr_data),
    .busy_out        (busy),
    .score_start_out (score_start),
    .rows_cleared_out(rows_cleared),
    .level_out       (level),
    .lines_out       (lines)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= (rd_addr < 5'd20) ? mem[rd_addr] : 10'd0;
    if (load_req) begin
      for (int i = 0; i < 20; i++) mem[i] <= init_board[i];
    end else if (wr_en && wr_addr < 5'd20) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rand_row(input int thresh);
    logic [9:0] v;
    if (int'($urandom_range(0, 99)) < thresh) return FULL;
    v = 10'($urandom);
    if (v == FULL) v = 10'h3fe;
    return v;
  endfunction

  task automatic load_board();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_start", score_start, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rows_cleared", rows_cleared, 0);
    check("rst_lines", lines, 0);
    check("rst_level", level, 1);
    check("rst_rd_addr", rd_addr, 19);
    check("rst_wr_addr", wr_addr, 19);
    check("rst_wr_data", wr_data, 0);
  endtask

  // Runs one clear pass on init_board; extra_at > 0 adds a stray lock at c+extra_at.
  task automatic run_pass(input int extra_at);
    int c, n, k, start_cyc, fall_cyc, n_start, n_wr, mism, lvl_before, late_wr;
    logic [9:0] exp_board [20];
    n = 0;
    k = 19;
    for (int r = 19; r >= 0; r--) begin
      if (init_board[r] == FULL) n++;
      else begin
        exp_board[k] = init_board[r];
        k--;
      end
    end
    for (int r = 0; r <= k; r++) exp_board[r] = 10'd0;
    lvl_before = lvl_m;

    load_board();
    lock = 1'b1;
    c = cyc;
    @(negedge clk);
    lock = 1'b0;
    check("busy_rise", busy, 1);
    start_cyc = -1;
    fall_cyc = -1;
    n_start = 0;
    n_wr = 0;
    for (int i = 0; i < 80 && fall_cyc < 0; i++) begin
      if (wr_en) n_wr++;
      if (score_start) begin
        n_start++;
        if (start_cyc < 0) start_cyc = cyc;
        check("rows_cleared", rows_cleared, (n > 7) ? 7 : n);
      end
      if (start_cyc >= 0 && cyc > start_cyc && cyc <= start_cyc + 3)
        check("level_hold", level, lvl_before);
      if (!busy) fall_cyc = cyc;
      else begin
        lock = (extra_at > 0 && cyc == c + extra_at);
        @(negedge clk);
      end
    end
    lock = 1'b0;
    check("start_delay", start_cyc - c, 23 + n);
    check("busy_fall_delay", fall_cyc - c, 28 + n);
    check("start_pulses", n_start, 1);
    check("write_count", n_wr, 20);

    lines_m = (lines_m + n > 999) ? 999 : lines_m + n;
    lvl_m = 1 + lines_m / 10;
    if (lvl_m > 29) lvl_m = 29;
    check("lines", lines, lines_m);
    check("level", level, lvl_m);

    late_wr = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en) late_wr++;
    end
    check("idle_after_pass", busy, 0);
    check("idle_writes", late_wr, 0);
    mism = 0;
    for (int r = 0; r < 20; r++) if (mem[r] !== exp_board[r]) mism++;
    check("board_rows_mismatched", mism, 0);
    pass_no++;
    $display("pass %0d: full_rows=%0d rows_cleared=%0d lines=%0d level=%0d",
             pass_no, n, rows_cleared, lines, level);
  endtask

  initial begin
    int c, n_wr, busy_seen;
    for (int r = 0; r < 20; r++) init_board[r] = 10'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    $display("reset: outputs checked");

    // No full rows: pure rewrite, nothing cleared.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(0);
    run_pass(0);

    // Bottom row full, row 18 drops into it.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(0);
    init_board[19] = FULL;
    init_board[18] = 10'b0000011111;
    run_pass(0);
    check("single_row19", mem[19], 10'b0000011111);
    check("single_row0", mem[0], 0);

    // Four bottom rows full.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(0);
    for (int r = 16; r < 20; r++) init_board[r] = FULL;
    init_board[15] = 10'h155;
    run_pass(0);
    check("tetris_row19", mem[19], 10'h155);
    check("tetris_row3", mem[3], 0);

    // Interleaved full rows 17 and 19.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(0);
    init_board[19] = FULL;
    init_board[17] = FULL;
    init_board[18] = 10'h2aa;
    init_board[16] = 10'h0f0;
    run_pass(0);
    check("split_row19", mem[19], 10'h2aa);
    check("split_row18", mem[18], 10'h0f0);
    check("split_row1", mem[1], 0);

    // Bring lines to 8, then clear 2 to cross into level 2.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(0);
    init_board[10] = FULL;
    run_pass(0);
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(0);
    init_board[19] = FULL;
    init_board[4] = FULL;
    run_pass(0);
    check("level_up_lines", lines, 10);
    check("level_up_level", level, 2);

    // Stray lock at c+5 must not start a second pass.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(20);
    run_pass(5);

    // Random boards, drifting past the line and level saturation points.
    for (int p = 0; p < 110; p++) begin
      int thresh;
      thresh = int'($urandom_range(0, 100));
      for (int r = 0; r < 20; r++) init_board[r] = rand_row(thresh);
      run_pass((p % 9 == 0) ? int'($urandom_range(2, 20)) : 0);
    end
    check("sat_lines", lines, 999);
    check("sat_level", level, 29);

    // Reset in the middle of a pass.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(30);
    load_board();
    lock = 1'b1;
    c = cyc;
    @(negedge clk);
    lock = 1'b0;
    while (cyc < c + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    lines_m = 0;
    lvl_m = 1;
    n_wr = 0;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr_en) n_wr++;
      if (busy) busy_seen++;
    end
    check("no_wr_after_rst", n_wr, 0);
    check("no_busy_after_rst", busy_seen, 0);
    $display("mid-pass reset: outputs checked");

    // Lock coincident with reset is dropped.
    rst = 1'b1;
    lock = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lock = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("lock_with_rst_dropped", busy_seen, 0);
    $display("lock with reset: checked");

    // Engine recovers normally after reset.
    for (int r = 0; r < 20; r++) init_board[r] = rand_row(25);
    run_pass(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
